// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative unsigned multiply/divide unit that sits beside the single-cycle
// ALU. One operation is in flight at a time. Requests come in through a
// valid/ready handshake. Results go out through a second valid/ready
// handshake that carries the request tag.
//
// Each normal operation runs for WIDTH iterations:
//   MUL / MULHU : shift-add into a 2*WIDTH product register
//   DIVU / REMU : restoring division, one quotient bit per cycle, MSB first
// Divide-by-zero and illegal op codes skip the iterations and respond on the
// cycle after accept.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous abort; discards any in-flight op
//   req_valid    request present
//   req_ready    unit can accept a request (IDLE only)
//   req_op       1001 MUL(lo), 1010 MULHU, 0100 DIVU, 0101 REMU
//   req_a        operand A (dividend / multiplicand), unsigned
//   req_b        operand B (divisor / multiplier), unsigned
//   req_tag      tag echoed on the response
//   resp_valid   result present (DONE only)
//   resp_ready   consumer accepts the result
//   resp_result  result
//   resp_tag     tag of the completed request
//   resp_err     illegal op code, or divide by zero
//   busy         high in any state other than IDLE
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_result,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_err,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] OP_MUL   = 4'b1001;
   localparam logic [3:0] OP_MULHU = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_REMU  = 4'b0101;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state, state_d;

   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q;      // multiplicand
   logic [WIDTH-1:0]   b_q;      // divisor
   logic [TAG_W-1:0]   tag_q;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] prod;     // upper half accumulates, lower half holds multiplier bits still to consume
   logic [WIDTH:0]     rem;      // partial remainder
   logic [WIDTH-1:0]   quot;     // dividend bits shift out the top, quotient bits shift in the bottom

   // Request decode
   logic accept;
   logic req_is_mul;
   logic req_is_div;
   logic req_div0;
   logic req_short;              // skips RUN and responds immediately
   logic last_iter;

   // One iteration of each algorithm
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_step;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH:0]     rem_step;
   logic [WIDTH-1:0]   quot_step;
   logic [WIDTH-1:0]   result_step;

   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_DONE);
   assign busy       = (state != S_IDLE);

   // flush beats the request handshake in the same cycle
   assign accept     = req_valid & req_ready & ~flush;
   assign req_is_mul = (req_op == OP_MUL)  || (req_op == OP_MULHU);
   assign req_is_div = (req_op == OP_DIVU) || (req_op == OP_REMU);
   assign req_div0   = req_is_div && (req_b == '0);
   assign req_short  = !(req_is_mul || req_is_div) || req_div0;
   assign last_iter  = (count == CNT_W'(WIDTH - 1));

   // Shift-add: the add carries into bit WIDTH, and that carry lands in the
   // product as the whole thing shifts right by one.
   assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]}
                    + (prod[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
   assign prod_step = {mul_sum, prod[WIDTH-1:1]};

   // Restoring divide: bring down the next dividend bit, subtract if it fits.
   assign div_shift = {rem[WIDTH-1:0], quot[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, b_q});
   assign rem_step  = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
   assign quot_step = {quot[WIDTH-2:0], div_ge};

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path through
      // the case leaves it unassigned and no latch is inferred.
      result_step = '0;
      case (op_q)
         OP_MUL:   result_step = prod_step[WIDTH-1:0];
         OP_MULHU: result_step = prod_step[2*WIDTH-1:WIDTH];
         OP_DIVU:  result_step = quot_step;
         OP_REMU:  result_step = rem_step[WIDTH-1:0];
         default:  result_step = '0;
      endcase
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values, independent of statement order.
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (accept)     state_d = req_short ? S_DONE : S_RUN;
            S_RUN:  if (last_iter)  state_d = S_DONE;
            S_DONE: if (resp_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         tag_q       <= '0;
         count       <= '0;
         prod        <= '0;
         rem         <= '0;
         quot        <= '0;
         resp_result <= '0;
         resp_tag    <= '0;
         resp_err    <= 1'b0;
      end else if (accept) begin
         op_q     <= req_op;
         a_q      <= req_a;
         b_q      <= req_b;
         tag_q    <= req_tag;
         count    <= '0;
         prod     <= {{WIDTH{1'b0}}, req_b};
         rem      <= '0;
         quot     <= req_a;
         resp_err <= req_short;
         // Short ops enter DONE on this edge, so their response is loaded now.
         if (req_short) begin
            resp_tag <= req_tag;
            if (!req_div0)              resp_result <= '0;
            else if (req_op == OP_DIVU) resp_result <= '1;
            else                        resp_result <= req_a;
         end
      end else if (state == S_RUN && !flush) begin
         count <= count + 1'b1;
         prod  <= prod_step;
         rem   <= rem_step;
         quot  <= quot_step;
         if (last_iter) begin
            resp_result <= result_step;
            resp_tag    <= tag_q;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed bench for muldiv_sequencer. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
// Latency counts falling edges after the accept edge, starting at 1.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

   localparam int WIDTH = 32;
   localparam int TAG_W = 4;

   localparam logic [3:0] OP_MUL   = 4'b1001;
   localparam logic [3:0] OP_MULHU = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_REMU  = 4'b0101;
   localparam logic [3:0] OP_BAD   = 4'b0000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [TAG_W-1:0] req_tag;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_result;
   logic [TAG_W-1:0] resp_tag;
   logic             resp_err;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_sequencer #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_tag     (req_tag),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_tag    (resp_tag),
      .resp_err    (resp_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Called right after an accept edge; returns at the first falling edge with
   // resp_valid=1, or with lat=-1 if none arrives within 100 cycles.
   task automatic wait_resp(output int lat);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (resp_valid !== 1'b1) lat = -1;
   endtask

   task automatic run_op(input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                         output int lat);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      @(posedge clk);
      wait_resp(lat);
   endtask

   task automatic handshake();
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      n_cmp++; if (req_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      n_cmp++; if (resp_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      n_cmp++; if (resp_result !== '0)   begin n_bad++; $display("FAIL reset_result: got %h want 0", resp_result); end
      n_cmp++; if (resp_tag !== '0)      begin n_bad++; $display("FAIL reset_tag: got %h want 0", resp_tag); end
      n_cmp++; if (resp_err !== 1'b0)    begin n_bad++; $display("FAIL reset_err: got %b want 0", resp_err); end
      n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mul();
      int lat;
      run_op(OP_MUL, 32'd7, 32'd6, 4'd3, lat);
      n_cmp++; if (lat !== 33)              begin n_bad++; $display("FAIL mul7x6_latency: got %0d want 33", lat); end
      n_cmp++; if (resp_result !== 32'd42)  begin n_bad++; $display("FAIL mul7x6_result: got %h want 2a", resp_result); end
      n_cmp++; if (resp_tag !== 4'd3)       begin n_bad++; $display("FAIL mul7x6_tag: got %h want 3", resp_tag); end
      n_cmp++; if (resp_err !== 1'b0)       begin n_bad++; $display("FAIL mul7x6_err: got %b want 0", resp_err); end
      handshake();

      run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, lat);
      n_cmp++; if (resp_result !== 32'h0000_0001) begin n_bad++; $display("FAIL mul_max_lo: got %h want 00000001", resp_result); end
      handshake();
      run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, lat);
      n_cmp++; if (resp_result !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mulhu_max: got %h want fffffffe", resp_result); end
      n_cmp++; if (lat !== 33)                    begin n_bad++; $display("FAIL mulhu_latency: got %0d want 33", lat); end
      handshake();
   endtask

   task automatic test_div();
      int lat;
      run_op(OP_DIVU, 32'd100, 32'd7, 4'd4, lat);
      n_cmp++; if (resp_result !== 32'd14) begin n_bad++; $display("FAIL divu_100_7: got %h want e", resp_result); end
      n_cmp++; if (lat !== 33)             begin n_bad++; $display("FAIL divu_latency: got %0d want 33", lat); end
      handshake();
      run_op(OP_REMU, 32'd100, 32'd7, 4'd5, lat);
      n_cmp++; if (resp_result !== 32'd2)  begin n_bad++; $display("FAIL remu_100_7: got %h want 2", resp_result); end
      n_cmp++; if (resp_tag !== 4'd5)      begin n_bad++; $display("FAIL remu_tag: got %h want 5", resp_tag); end
      handshake();

      run_op(OP_DIVU, 32'd5, 32'd0, 4'd6, lat);
      n_cmp++; if (lat !== 1)                     begin n_bad++; $display("FAIL divu_zero_latency: got %0d want 1", lat); end
      n_cmp++; if (resp_result !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divu_zero_result: got %h want ffffffff", resp_result); end
      n_cmp++; if (resp_err !== 1'b1)             begin n_bad++; $display("FAIL divu_zero_err: got %b want 1", resp_err); end
      handshake();
      run_op(OP_REMU, 32'd5, 32'd0, 4'd7, lat);
      n_cmp++; if (lat !== 1)               begin n_bad++; $display("FAIL remu_zero_latency: got %0d want 1", lat); end
      n_cmp++; if (resp_result !== 32'd5)   begin n_bad++; $display("FAIL remu_zero_result: got %h want 5", resp_result); end
      n_cmp++; if (resp_err !== 1'b1)       begin n_bad++; $display("FAIL remu_zero_err: got %b want 1", resp_err); end
      handshake();
      run_op(OP_BAD, 32'd11, 32'd22, 4'd8, lat);
      n_cmp++; if (lat !== 1)               begin n_bad++; $display("FAIL illegal_latency: got %0d want 1", lat); end
      n_cmp++; if (resp_result !== '0)      begin n_bad++; $display("FAIL illegal_result: got %h want 0", resp_result); end
      n_cmp++; if (resp_err !== 1'b1)       begin n_bad++; $display("FAIL illegal_err: got %b want 1", resp_err); end
      n_cmp++; if (resp_tag !== 4'd8)       begin n_bad++; $display("FAIL illegal_tag: got %h want 8", resp_tag); end
      handshake();
   endtask

   task automatic test_backpressure();
      int lat;
      run_op(OP_MUL, 32'd12, 32'd11, 4'd5, lat);
      n_cmp++; if (resp_result !== 32'd132) begin n_bad++; $display("FAIL bp_result: got %h want 84", resp_result); end
      n_cmp++; if (resp_err !== 1'b0)       begin n_bad++; $display("FAIL bp_err_cleared: got %b want 0", resp_err); end
      // A competing request is presented while the response is stalled.
      req_valid = 1'b1;
      req_op    = OP_DIVU;
      req_a     = 32'd20;
      req_b     = 32'd4;
      req_tag   = 4'd9;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({resp_valid, req_ready, resp_tag, resp_result} !== {1'b1, 1'b0, 4'd5, 32'd132}) begin
            n_bad++;
            $display("FAIL bp_hold_%0d: got valid=%b ready=%b tag=%h result=%h want 1 0 5 84",
                     i, resp_valid, req_ready, resp_tag, resp_result);
         end
      end
      handshake();
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_drop: got %b want 0", resp_valid); end
      n_cmp++; if (req_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
      @(posedge clk);
      wait_resp(lat);
      n_cmp++; if (lat !== 33)            begin n_bad++; $display("FAIL bp_next_latency: got %0d want 33", lat); end
      n_cmp++; if (resp_result !== 32'd5) begin n_bad++; $display("FAIL bp_next_result: got %h want 5", resp_result); end
      n_cmp++; if (resp_tag !== 4'd9)     begin n_bad++; $display("FAIL bp_next_tag: got %h want 9", resp_tag); end
      handshake();
   endtask

   task automatic test_flush();
      int lat;
      logic saw;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_MUL;
      req_a     = 32'd9;
      req_b     = 32'd9;
      req_tag   = 4'd7;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;              // count=0 here
      repeat (10) @(negedge clk);    // count=10 here
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before: got %b want 1", busy); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_cmp++; if ({busy, req_ready, resp_valid} !== 3'b010) begin
         n_bad++; $display("FAIL flush_to_idle: got busy/ready/valid=%b want 010", {busy, req_ready, resp_valid});
      end
      saw = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid === 1'b1) saw = 1'b1;
      end
      n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL flush_no_resp: got resp_valid seen=%b want 0", saw); end

      // flush in IDLE blocks a concurrent request
      req_valid = 1'b1;
      flush     = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      flush     = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_blocks_accept: got busy=%b want 0", busy); end

      run_op(OP_DIVU, 32'd9, 32'd3, 4'd6, lat);
      n_cmp++; if (resp_result !== 32'd3) begin n_bad++; $display("FAIL flush_next_divu: got %h want 3", resp_result); end
      n_cmp++; if (lat !== 33)            begin n_bad++; $display("FAIL flush_next_latency: got %0d want 33", lat); end
      handshake();
   endtask

   task automatic test_async_reset();
      int lat;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_MUL;
      req_a     = 32'd100;
      req_b     = 32'd100;
      req_tag   = 4'd2;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;               // between edges
      #1;
      n_cmp++; if ({req_ready, resp_valid, busy, resp_err} !== 4'b1000) begin
         n_bad++; $display("FAIL arst_ctrl: got ready/valid/busy/err=%b want 1000", {req_ready, resp_valid, busy, resp_err});
      end
      n_cmp++; if (resp_result !== '0) begin n_bad++; $display("FAIL arst_result: got %h want 0", resp_result); end
      n_cmp++; if (resp_tag !== '0)    begin n_bad++; $display("FAIL arst_tag: got %h want 0", resp_tag); end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(OP_MUL, 32'd2, 32'd3, 4'd1, lat);
      n_cmp++; if (resp_result !== 32'd6) begin n_bad++; $display("FAIL arst_next_mul: got %h want 6", resp_result); end
      n_cmp++; if (lat !== 33)            begin n_bad++; $display("FAIL arst_next_latency: got %0d want 33", lat); end
      n_cmp++; if (resp_tag !== 4'd1)     begin n_bad++; $display("FAIL arst_next_tag: got %h want 1", resp_tag); end
      handshake();
   endtask

   initial begin
      flush      = 1'b0;
      req_valid  = 1'b0;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      req_tag    = '0;
      resp_ready = 1'b0;
      test_reset();
      test_mul();
      test_div();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
